// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline controller FSM state and register-index width.
package cpu_types_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Datapath <-> pipeline controller bundle; master is the controller, slave the datapath.
interface pipeline_controller_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     halt_wb;
  logic     ex_dREN;
  reg_idx_t ex_wsel;
  reg_idx_t id_rs;
  reg_idx_t id_rt;
  logic     ex_branch_taken;
  logic     id_jump;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     dmem_req;
  logic     halted;

  modport master (
    input  ihit, dhit, mem_dREN, mem_dWEN, halt_wb, ex_dREN, ex_wsel, id_rs, id_rt,
           ex_branch_taken, id_jump,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, halted
  );

  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, halt_wb, ex_dREN, ex_wsel, id_rs, id_rt,
           ex_branch_taken, id_jump,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, dmem_req, halted
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  reg_idx_t ex_wsel,
  input  reg_idx_t id_rs,
  input  reg_idx_t id_rt,
  output logic     load_use
);

  // $zero is never a real dependency
  assign load_use = ex_dREN && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline stall/flush controller; all enables/flushes are combinational from state+inputs.
// Optional PIPE_PERF_EN adds saturating stall_cnt/flush_cnt counters.
module pipeline_controller
  import cpu_types_pkg::*;
(
  input  logic                   CLK,
  input  logic                   nRST,
  pipeline_controller_if.master  bus
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  pipe_state_t state, next_state;
  logic        hit_q;
  logic        mem_req;
  logic        data_stall;
  logic        load_use;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic dmem_req, halted;

  assign mem_req    = bus.mem_dREN || bus.mem_dWEN;
  assign data_stall = !bus.dhit && ((state == DWAIT) || ((state == RUN) && mem_req));

  hazard_detect u_hazard (
    .ex_dREN  (bus.ex_dREN),
    .ex_wsel  (bus.ex_wsel),
    .id_rs    (bus.id_rs),
    .id_rt    (bus.id_rt),
    .load_use (load_use)
  );

  // hit_q masks the request for one cycle after a completed access, while MEM
  // still shows the old instruction's strobes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      hit_q <= 1'b0;
    end else begin
      state <= next_state;
      hit_q <= (state != HALT) && bus.dhit && (mem_req || (state == DWAIT));
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mem_req && !bus.dhit) next_state = DWAIT;
      DWAIT:   if (bus.dhit) next_state = RUN;
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
    if (bus.halt_wb && memwb_en) next_state = HALT;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    dmem_req    = mem_req && !hit_q;
    halted      = 1'b0;
    if (!nRST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en}         = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
      dmem_req = 1'b0;
    end else if (state == HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      dmem_req = 1'b0;
      halted   = 1'b1;
    end else if (data_stall) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      dmem_req = !hit_q;
    end else if (bus.ex_branch_taken) begin
      pc_en      = bus.ihit;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (bus.id_jump && bus.ihit) begin
      ifid_flush = 1'b1;
    end else if (!bus.ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.dmem_req    = dmem_req;
  assign bus.halted      = halted;

`ifdef PIPE_PERF_EN
  logic any_flush;
  assign any_flush = ifid_flush || idex_flush || exmem_flush || memwb_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: expected control vectors queued per driven cycle.
module tb_pipeline_controller;

  typedef struct packed {
    logic       ihit, dhit, mem_dREN, mem_dWEN, halt_wb, ex_dREN;
    logic [4:0] ex_wsel, id_rs, id_rt;
    logic       ex_branch_taken, id_jump;
  } in_t;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, dmem_req, halted}
  localparam logic [10:0] E_RST   = 11'b00000_1111_0_0;
  localparam logic [10:0] E_RUN   = 11'b11111_0000_0_0;
  localparam logic [10:0] E_RUNRQ = 11'b11111_0000_1_0;
  localparam logic [10:0] E_DSTL  = 11'b00000_0000_1_0;
  localparam logic [10:0] E_DSTL0 = 11'b00000_0000_0_0;
  localparam logic [10:0] E_LU    = 11'b00111_0100_0_0;
  localparam logic [10:0] E_BR    = 11'b11111_1100_0_0;
  localparam logic [10:0] E_BRFS  = 11'b01111_1100_0_0;
  localparam logic [10:0] E_JMP   = 11'b11111_1000_0_0;
  localparam logic [10:0] E_FS    = 11'b01111_1000_0_0;
  localparam logic [10:0] E_HALT  = 11'b00000_0000_0_1;

  logic CLK;
  logic nRST;
  int   n_chk;
  int   n_fail;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  pipeline_controller_if pif();

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipeline_controller dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (pif.master)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_chk++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, obs_v, exp_v);
    end
  endtask

  function automatic in_t idle();
    in_t r;
    r = '0;
    r.ihit = 1'b1;
    return r;
  endfunction

  function automatic logic [10:0] obs();
    return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
            pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush,
            pif.dmem_req, pif.halted};
  endfunction

  task automatic drive(input in_t s);
    pif.ihit            = s.ihit;
    pif.dhit            = s.dhit;
    pif.mem_dREN        = s.mem_dREN;
    pif.mem_dWEN        = s.mem_dWEN;
    pif.halt_wb         = s.halt_wb;
    pif.ex_dREN         = s.ex_dREN;
    pif.ex_wsel         = s.ex_wsel;
    pif.id_rs           = s.id_rs;
    pif.id_rt           = s.id_rt;
    pif.ex_branch_taken = s.ex_branch_taken;
    pif.id_jump         = s.id_jump;
  endtask

  // One clock: drive, queue the expectation, compare at negedge, land at posedge+1.
  task automatic cyc(input in_t s, input logic [10:0] e, input string tag);
    logic [10:0] ev;
    string       tg;
    drive(s);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge CLK);
    ev = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk(tg, {21'd0, obs()}, {21'd0, ev});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in_t s;
    n_chk  = 0;
    n_fail = 0;
    nRST   = 1'b0;
    s = idle(); s.mem_dREN = 1'b1;
    drive(s);
    @(negedge CLK);
    chk("reset_outputs", {21'd0, obs()}, {21'd0, E_RST});
`ifdef PIPE_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge CLK); #1;
    nRST = 1'b1;

    cyc(idle(), E_RUN, "idle_run");

    // miss held three cycles, then hit
    s = idle(); s.mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) cyc(s, E_DSTL, "load_miss_stall");
    s.dhit = 1'b1;
    cyc(s, E_RUNRQ, "load_hit_release");
    s.dhit = 1'b0;
    cyc(s, E_DSTL0, "req_gap_after_hit");
    s = idle();
    cyc(s, E_DSTL, "dwait_holds");
    s.mem_dREN = 1'b1; s.dhit = 1'b1;
    cyc(s, E_RUNRQ, "dwait_hit_release");
    cyc(idle(), E_RUN, "idle_after_hit");
    s = idle(); s.mem_dWEN = 1'b1; s.dhit = 1'b1;
    cyc(s, E_RUNRQ, "store_hit_run");
    cyc(idle(), E_RUN, "idle_after_store");

    // load-use hazards
    s = idle(); s.ex_dREN = 1'b1; s.ex_wsel = 5'd8; s.id_rt = 5'd8;
    cyc(s, E_LU, "load_use_rt");
    s.id_rt = 5'd0; s.id_rs = 5'd8;
    cyc(s, E_LU, "load_use_rs");
    s.ex_wsel = 5'd0; s.id_rs = 5'd0;
    cyc(s, E_RUN, "load_use_r0_ignored");
    s.ex_wsel = 5'd8; s.id_rs = 5'd3; s.id_rt = 5'd4;
    cyc(s, E_RUN, "load_no_dep");
    s.id_rt = 5'd8; s.id_jump = 1'b1;
    cyc(s, E_LU, "load_use_over_jump");

    // branch, jump, fetch stall
    s = idle(); s.ex_branch_taken = 1'b1; s.ex_dREN = 1'b1; s.ex_wsel = 5'd5; s.id_rs = 5'd5;
    cyc(s, E_BR, "branch_over_load_use");
    s.ihit = 1'b0;
    cyc(s, E_BRFS, "branch_with_fetch_stall");
    s = idle(); s.id_jump = 1'b1;
    cyc(s, E_JMP, "id_jump");
    s.ihit = 1'b0;
    cyc(s, E_FS, "jump_without_ihit");
    s = idle(); s.ihit = 1'b0;
    cyc(s, E_FS, "fetch_stall");

    // data stall dominates branch
    s = idle(); s.mem_dREN = 1'b1; s.ex_branch_taken = 1'b1;
    cyc(s, E_DSTL, "dstall_over_branch");
    s = idle(); s.mem_dREN = 1'b1; s.dhit = 1'b1;
    cyc(s, E_RUNRQ, "dstall_branch_release");
    cyc(idle(), E_RUN, "idle_after_branch_miss");

    // halt_wb is ignored while memwb is frozen
    s = idle(); s.mem_dREN = 1'b1; s.halt_wb = 1'b1;
    cyc(s, E_DSTL, "halt_wb_while_stalled");
    s = idle(); s.mem_dREN = 1'b1; s.dhit = 1'b1;
    cyc(s, E_RUNRQ, "no_halt_after_stall");
    cyc(idle(), E_RUN, "idle_before_rst");

    // reset in the middle of a miss
    s = idle(); s.mem_dREN = 1'b1;
    cyc(s, E_DSTL, "miss_before_rst");
    nRST = 1'b0;
    cyc(s, E_RST, "rst_in_dwait");
    nRST = 1'b1;
    cyc(idle(), E_RUN, "run_after_rst");
`ifdef PIPE_PERF_EN
    chk("perf_stall_cleared", stall_cnt, 32'd0);
    chk("perf_flush_cleared", flush_cnt, 32'd0);
`endif

    s = idle(); s.ihit = 1'b0;
    for (int i = 0; i < 5; i++) cyc(s, E_FS, "perf_fetch_stall");
    s = idle(); s.ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) cyc(s, E_BR, "perf_branch");
`ifdef PIPE_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 32'd5);
    chk("perf_flush_cnt", flush_cnt, 32'd7);
`endif

    // halt and absorbing behaviour
    s = idle(); s.halt_wb = 1'b1;
    cyc(s, E_RUN, "halt_wb_retire");
    cyc(idle(), E_HALT, "halted");
    s = idle(); s.ihit = 1'b0; s.dhit = 1'b1; s.mem_dREN = 1'b1; s.ex_branch_taken = 1'b1;
    cyc(s, E_HALT, "halt_toggle_a");
    s = idle(); s.mem_dREN = 1'b1;
    cyc(s, E_HALT, "halt_toggle_b");
    s = idle(); s.dhit = 1'b1; s.halt_wb = 1'b1;
    cyc(s, E_HALT, "halt_toggle_c");
`ifdef PIPE_PERF_EN
    chk("perf_stall_frozen", stall_cnt, 32'd5);
    chk("perf_flush_frozen", flush_cnt, 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have ports: CLK in 1 (clock); nRST in 1 (reset, asynchronous, active-low).
REQ-002 SHALL have: ihit in 1 (instruction fetch complete this cycle); dhit in 1 (data access complete this cycle).
REQ-003 SHALL have: mem_dREN in 1, mem_dWEN in 1 (load/store in MEM stage); halt_wb in 1 (halt instruction in WB stage).
REQ-004 SHALL have: ex_dREN in 1 (load in EX); ex_wsel in 5 (EX destination reg); id_rs in 5, id_rt in 5 (ID source regs).
REQ-005 SHALL have: ex_branch_taken in 1 (branch/jump-register resolved taken in EX); id_jump in 1 (J/JAL decoded in ID).
REQ-006 SHALL have outputs, 1 bit each: pc_en; ifid_en, idex_en, exmem_en, memwb_en; ifid_flush, idex_flush, exmem_flush, memwb_flush.
REQ-007 SHALL have outputs: dmem_req 1 (gated MEM-stage request to cache); halted 1.

Function
REQ-008 SHALL implement FSM states RUN, DWAIT, HALT; reset state RUN.
REQ-009 RUN->DWAIT when (mem_dREN|mem_dWEN) & !dhit; DWAIT->RUN on dhit; any state->HALT when halt_wb=1 and memwb_en=1 in the same cycle; HALT is absorbing until reset.
REQ-010 Stall priority, highest first: HALT, data stall, EX flush, load-use, ID jump, fetch stall.
REQ-011 HALT: all en=0, all flush=0, dmem_req=0, halted=1.
REQ-012 Data stall (DWAIT, or RUN with pending miss): pc_en and all four en=0, all flush=0, dmem_req=1.
REQ-013 dhit cycle: all en=1 that cycle; dmem_req=0 in the following cycle until the new MEM instruction is latched.
REQ-014 EX flush (ex_branch_taken): pc_en=1, ifid_flush=1, idex_flush=1, exmem/memwb advance.
REQ-015 Load-use: ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt) -> pc_en=0, ifid_en=0, idex_flush=1, others advance.
REQ-016 ID jump (id_jump & ihit): ifid_flush=1 only.
REQ-017 Fetch stall (!ihit): pc_en=0, ifid_flush=1 (bubble); downstream stages advance.
REQ-018 A flush SHALL never be asserted on a stage whose en is 0 in the same cycle.
REQ-019 All en/flush/dmem_req outputs SHALL be combinational from state and inputs (zero latency); only state and counters are registered.
REQ-020 Simultaneous EX flush and fetch stall: pc_en=0, ifid_flush=1, idex_flush=1.

Reset
REQ-021 nRST low: state RUN, halted=0, counters 0 within same delta; reset mid-DWAIT SHALL abandon the access (dmem_req=0 while nRST low).
REQ-022 While in reset all en=0 and all flush=1.

Configuration
REQ-023 With PIPE_PERF_EN defined: outputs stall_cnt 32 and flush_cnt 32, counting cycles with pc_en=0 and cycles with any flush=1, saturating at 0xFFFFFFFF, frozen in HALT.
REQ-024 Without PIPE_PERF_EN: counter ports and logic absent; all other behaviour identical.

Structure
REQ-025 FSM state enum pipe_state_t {RUN, DWAIT, HALT} and reg-index width constant SHALL live in cpu_types_pkg.
REQ-026 Hazard detection (REQ-015) SHALL be sub-module hazard_detect; perf counters inline.

Verification
REQ-027 mem_dREN=1, dhit=0 for 3 cycles then 1 -> all en=0 3 cycles, state DWAIT, all en=1 on dhit cycle, then RUN.
REQ-028 ex_dREN=1, ex_wsel=8, id_rt=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; ex_wsel=0 -> no stall.
REQ-029 ex_branch_taken=1 with ex_dREN=1, ex_wsel=id_rs=5 -> ifid_flush=idex_flush=1, pc_en=1 (flush beats load-use).
REQ-030 halt_wb=1, memwb_en=1 -> next cycle halted=1, all en=0; ihit/dhit toggling thereafter causes no change.
REQ-031 nRST pulsed low during DWAIT -> dmem_req=0 immediately, state RUN after release.
REQ-032 PIPE_PERF_EN: 5 fetch-stall cycles + 2 branch flushes -> stall_cnt=5, flush_cnt=7.
